issue_queue_param: RTL and testbench

Parametrised in-order issue queue for the Tomasulo core. It sits between the instruction register/decoder and the ROB, ALU reservation stations and load/store station. Decoded control words are buffered in a circular FIFO and issued one per cycle from the head, when the ROB and the selected station can accept them. Compared with the fixed iq, it adds configurable depth and station count, round-robin ALU station selection, a branch-mispredict flush and a stall-cycle counter.

---
 rtl/issue_queue_param.sv | 122 ++++++++++++
 tb/tb_issue_queue_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_param.sv
// In-order issue queue: circular FIFO of decoded words, issued from the head
// to the ROB plus either the ldst station or a round-robin-chosen ALU station.
module issue_queue_param #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = 32,
  parameter int NUM_RS = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [WORD_W-1:0] enq_word,
  input  logic              enq_is_mem,
  output logic              enq_ready,
  input  logic              rob_full,
  input  logic              ldst_q_full,
  input  logic [NUM_RS-1:0] res_empty,
  input  logic              resldst_empty,
  output logic              rob_load,
  output logic [NUM_RS-1:0] res_load,
  output logic              resldst_load,
  output logic [WORD_W-1:0] control_o,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic [15:0]       stall_cycles
);

  localparam int RR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [WORD_W-1:0] word_mem [DEPTH];
  logic [DEPTH-1:0]  mem_flag;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count_q;
  logic [RR_W-1:0]   rr_ptr;
  logic [15:0]       stall_q;

  logic              head_is_mem;
  logic              can_alu;
  logic              sel_found;
  logic [RR_W-1:0]   sel_idx;
  logic [RR_W-1:0]   rr_next;
  logic              do_enq;
  logic              do_issue;

  assign empty        = (count_q == '0);
  assign enq_ready    = (count_q != (PTR_W+1)'(DEPTH));
  assign count        = count_q;
  assign control_o    = word_mem[head];
  assign head_is_mem  = mem_flag[head];
  assign can_alu      = |res_empty;
  assign stall_cycles = stall_q;

  assign do_enq   = enq_valid && enq_ready && !flush;
  assign do_issue = !empty && !flush && !rob_full &&
                    (head_is_mem ? (resldst_empty && !ldst_q_full) : can_alu);

  // Scan free ALU stations starting at rr_ptr, wrapping at NUM_RS.
  always_comb begin
    int idx;
    logic [RR_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_RS;
      cand = RR_W'(idx);
      if (!sel_found && res_empty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    rr_next = RR_W'((int'(sel_idx) + 1) % NUM_RS);
  end

  always_comb begin
    rob_load     = do_issue;
    resldst_load = do_issue && head_is_mem;
    res_load     = '0;
    if (do_issue && !head_is_mem)
      res_load[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      rr_ptr   <= '0;
      stall_q  <= '0;
      mem_flag <= '0;
      for (int i = 0; i < DEPTH; i++)
        word_mem[i] <= '0;
    end else if (flush) begin
      // Mispredict: drop everything queued; stale entries are simply unreachable.
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      rr_ptr  <= '0;
    end else begin
      if (do_enq) begin
        word_mem[tail] <= enq_word;
        mem_flag[tail] <= enq_is_mem;
        tail           <= tail + PTR_W'(1);
      end
      if (do_issue) begin
        head <= head + PTR_W'(1);
        if (!head_is_mem)
          rr_ptr <= rr_next;
      end
      if (do_enq && !do_issue)
        count_q <= count_q + (PTR_W+1)'(1);
      else if (!do_enq && do_issue)
        count_q <= count_q - (PTR_W+1)'(1);
      if (!empty && !do_issue && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Self-checking bench for issue_queue_param: a directed vector table followed
// by hand-written sequences for fill/full, round robin, blocking, flush, reset and wrap.
module tb_issue_queue_param;

  localparam int DEPTH  = 8;
  localparam int WORD_W = 32;
  localparam int NUM_RS = 4;
  localparam int PTR_W  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              enq_valid = 1'b0;
  logic [WORD_W-1:0] enq_word = '0;
  logic              enq_is_mem = 1'b0;
  logic              enq_ready;
  logic              rob_full = 1'b0;
  logic              ldst_q_full = 1'b0;
  logic [NUM_RS-1:0] res_empty = '0;
  logic              resldst_empty = 1'b0;
  logic              rob_load;
  logic [NUM_RS-1:0] res_load;
  logic              resldst_load;
  logic [WORD_W-1:0] control_o;
  logic [PTR_W:0]    count;
  logic              empty;
  logic [15:0]       stall_cycles;

  int total = 0;
  int bad   = 0;

  issue_queue_param #(.DEPTH(DEPTH), .WORD_W(WORD_W), .NUM_RS(NUM_RS)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_word(enq_word), .enq_is_mem(enq_is_mem),
    .enq_ready(enq_ready), .rob_full(rob_full), .ldst_q_full(ldst_q_full),
    .res_empty(res_empty), .resldst_empty(resldst_empty),
    .rob_load(rob_load), .res_load(res_load), .resldst_load(resldst_load),
    .control_o(control_o), .count(count), .empty(empty),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, ev;
    logic [31:0] w;
    logic        im, rf, lf;
    logic [3:0]  re;
    logic        le;
    logic        rl;
    logic [3:0]  res;
    logic        ldl;
    logic [31:0] ctl;
    logic [3:0]  cnt;
    logic        emp, rdy;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs[9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic apply_stimulus(input logic fl, input logic ev, input logic [31:0] w,
                                input logic im, input logic rf, input logic lf,
                                input logic [3:0] re, input logic le);
    @(negedge clk);
    flush = fl; enq_valid = ev; enq_word = w; enq_is_mem = im;
    rob_full = rf; ldst_q_full = lf; res_empty = re; resldst_empty = le;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    flush = 1'b0; enq_valid = 1'b0; enq_word = '0; enq_is_mem = 1'b0;
    rob_full = 1'b0; ldst_q_full = 1'b0; res_empty = '0; resldst_empty = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : main
    logic [32:0] model[$];
    logic [32:0] exp_ent;
    int sent;
    int got;

    // fl ev  word       im rf lf re       le | rl res     ldl ctl        cnt emp rdy stall
    vecs[0] = '{1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,4'b1111,1'b0, 1'b0,4'b0000,1'b0,32'h0,  4'd0,1'b1,1'b1,16'd0};
    vecs[1] = '{1'b0,1'b1,32'hA1, 1'b0,1'b0,1'b0,4'b0000,1'b0, 1'b0,4'b0000,1'b0,32'h0,  4'd0,1'b1,1'b1,16'd0};
    vecs[2] = '{1'b0,1'b1,32'hA2, 1'b0,1'b0,1'b0,4'b0000,1'b0, 1'b0,4'b0000,1'b0,32'hA1, 4'd1,1'b0,1'b1,16'd0};
    vecs[3] = '{1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,4'b1111,1'b0, 1'b1,4'b0001,1'b0,32'hA1, 4'd2,1'b0,1'b1,16'd1};
    vecs[4] = '{1'b0,1'b1,32'hB1, 1'b1,1'b0,1'b0,4'b1111,1'b0, 1'b1,4'b0010,1'b0,32'hA2, 4'd1,1'b0,1'b1,16'd1};
    vecs[5] = '{1'b0,1'b0,32'h0,  1'b0,1'b0,1'b1,4'b1111,1'b1, 1'b0,4'b0000,1'b0,32'hB1, 4'd1,1'b0,1'b1,16'd1};
    vecs[6] = '{1'b0,1'b0,32'h0,  1'b0,1'b1,1'b0,4'b1111,1'b1, 1'b0,4'b0000,1'b0,32'hB1, 4'd1,1'b0,1'b1,16'd2};
    vecs[7] = '{1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,4'b1111,1'b1, 1'b1,4'b0000,1'b1,32'hB1, 4'd1,1'b0,1'b1,16'd3};
    vecs[8] = '{1'b1,1'b1,32'hA3, 1'b0,1'b0,1'b0,4'b1111,1'b1, 1'b0,4'b0000,1'b0,32'h0,  4'd0,1'b1,1'b1,16'd3};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].fl, vecs[i].ev, vecs[i].w, vecs[i].im,
                     vecs[i].rf, vecs[i].lf, vecs[i].re, vecs[i].le);
      check_output($sformatf("v%0d_rob_load", i),     rob_load,     vecs[i].rl);
      check_output($sformatf("v%0d_res_load", i),     res_load,     vecs[i].res);
      check_output($sformatf("v%0d_resldst_load", i), resldst_load, vecs[i].ldl);
      check_output($sformatf("v%0d_control_o", i),    control_o,    vecs[i].ctl);
      check_output($sformatf("v%0d_count", i),        count,        vecs[i].cnt);
      check_output($sformatf("v%0d_empty", i),        empty,        vecs[i].emp);
      check_output($sformatf("v%0d_enq_ready", i),    enq_ready,    vecs[i].rdy);
      check_output($sformatf("v%0d_stall", i),        stall_cycles, vecs[i].stall);
    end

    // Fill to full with no ALU station free, then drain in order with round robin.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'd100 + i, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      check_output($sformatf("full_ready%0d", i), enq_ready, (i < 8) ? 1 : 0);
      check_output($sformatf("full_noissue%0d", i), rob_load, 0);
    end
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
      if (i == 0) check_output("full_count", count, 8);
      check_output($sformatf("drain_rl%0d", i), rob_load, 1);
      check_output($sformatf("drain_word%0d", i), control_o, 32'd100 + i);
      check_output($sformatf("drain_rs%0d", i), res_load, 32'(1 << (i % 4)));
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    check_output("drain_empty", empty, 1);
    check_output("drain_no9th", rob_load, 0);

    // Round robin skipping busy stations once rr_ptr has wrapped to 1.
    do_reset();
    for (int i = 0; i < 7; i++)
      apply_stimulus(1'b0, 1'b1, 32'd200 + i, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
      check_output($sformatf("rr_rs%0d", i), res_load, 32'(1 << (i % 4)));
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
    check_output("rr_skip_a", res_load, 4'b0010);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
    check_output("rr_skip_b", res_load, 4'b1000);

    // Memory word blocked at the head holds back the ALU word behind it.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1);
    apply_stimulus(1'b0, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    check_output("blk_rl0", rob_load, 0);
    check_output("blk_rs0", res_load, 0);
    for (int i = 1; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
      check_output($sformatf("blk_rl%0d", i), rob_load, 0);
      check_output($sformatf("blk_ldl%0d", i), resldst_load, 0);
      check_output($sformatf("blk_rs%0d", i), res_load, 0);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    check_output("blk_stall", stall_cycles, 4);
    check_output("blk_mem_rl", rob_load, 1);
    check_output("blk_mem_ldl", resldst_load, 1);
    check_output("blk_mem_word", control_o, 32'hC0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    check_output("blk_alu_rl", rob_load, 1);
    check_output("blk_alu_rs", res_load, 4'b0001);
    check_output("blk_alu_word", control_o, 32'hC1);

    // Flush with a word presented: nothing issues and that word is lost.
    do_reset();
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b0, 1'b1, 32'd300 + i, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    check_output("fl_count5", count, 5);
    check_output("fl_rl", rob_load, 0);
    check_output("fl_rs", res_load, 0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_output("fl_count0", count, 0);
    check_output("fl_empty", empty, 1);
    apply_stimulus(1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    check_output("fl_new_word", control_o, 32'hBEEF);
    check_output("fl_new_count", count, 1);
    check_output("fl_new_rl", rob_load, 1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    check_output("fl_after_empty", empty, 1);

    // Asynchronous reset between edges discards queued words immediately.
    do_reset();
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 1'b1, 32'd400 + i, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    check_output("rst_pre_count", count, 3);
    #1 reset_n = 1'b0;
    #1;
    check_output("rst_count", count, 0);
    check_output("rst_empty", empty, 1);
    check_output("rst_ready", enq_ready, 1);
    check_output("rst_ctl", control_o, 0);
    check_output("rst_rl", rob_load, 0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 32'h7777, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    check_output("rst_first_word", control_o, 32'h7777);
    check_output("rst_first_rl", rob_load, 1);

    // Stream 20 tagged words through random backpressure across pointer wrap.
    do_reset();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      flush         = 1'b0;
      enq_valid     = (sent < 20);
      enq_word      = 32'h1000 + sent;
      enq_is_mem    = 1'($urandom_range(0, 1));
      res_empty     = 4'($urandom_range(0, 15));
      rob_full      = ($urandom_range(0, 3) == 0);
      ldst_q_full   = ($urandom_range(0, 3) == 0);
      resldst_empty = 1'($urandom_range(0, 1));
      #1;
      check_output("stream_count", count, model.size());
      if (rob_load) begin
        if (model.size() == 0) begin
          check_output("stream_spurious", rob_load, 0);
        end else begin
          exp_ent = model.pop_front();
          check_output("stream_order", control_o, exp_ent[31:0]);
          check_output("stream_route", resldst_load, exp_ent[32]);
          got++;
        end
      end
      if (enq_valid && enq_ready) begin
        model.push_back({enq_is_mem, enq_word});
        sent++;
      end
    end
    check_output("stream_all_issued", got, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
